// File: rtl/alu_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_hs
// Purpose  : Handshaked RV32I-style ALU stage. It supports the full ALU op set
//            and all six branch compares. Shifts run on a multi-cycle iterative
//            shifter. A one-entry output hold register absorbs downstream stalls.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN        operand/result width (>= 8, power of 2)
//   SHIFT_STEP  bit positions shifted per BUSY cycle (1..XLEN)
// Ports
//   clk        in   1     clock, all state on rising edge
//   rst_n      in   1     synchronous active-low reset
//   in_valid   in   1     operation request
//   in_ready   out  1     request accepted this cycle
//   op         in   5     operation code
//   alusrc     in   1     1: B = sext(imm), 0: B = rs2 (ignored for branches)
//   rs1        in   XLEN  operand A
//   rs2        in   XLEN  register operand B
//   imm        in   12    two's complement immediate
//   branch     in   1     instruction is a conditional branch
//   out_valid  out  1     result/flags valid
//   out_ready  in   1     consumer takes result
//   result     out  XLEN  ALU result
//   zero       out  1     result == 0
//   pcsrc      out  1     branch & condition true
//   busy       out  1     multi-cycle operation in progress
// Configuration macro
//   ALU_PIPE_HS_MUL_EN  adds op 10000 = MUL (iterative shift-add, XLEN+1 latency)
// ============================================================================
module alu_pipe_hs #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            alusrc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [11:0]     imm,
  input  logic            branch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            pcsrc,
  output logic            busy
);

  localparam int LOG = $clog2(XLEN);
  // One extra bit so the remaining count can hold XLEN (multiplier countdown).
  localparam int CW  = LOG + 1;
  localparam logic [CW-1:0] c_STEP = CW'(SHIFT_STEP);

  localparam logic [4:0] c_OP_ADD  = 5'b00000;
  localparam logic [4:0] c_OP_SUB  = 5'b00001;
  localparam logic [4:0] c_OP_XOR  = 5'b00010;
  localparam logic [4:0] c_OP_OR   = 5'b00011;
  localparam logic [4:0] c_OP_AND  = 5'b00100;
  localparam logic [4:0] c_OP_SLL  = 5'b00101;
  localparam logic [4:0] c_OP_SRL  = 5'b00110;
  localparam logic [4:0] c_OP_SRA  = 5'b00111;
  localparam logic [4:0] c_OP_SLT  = 5'b01000;
  localparam logic [4:0] c_OP_SLTU = 5'b01001;
  localparam logic [4:0] c_OP_BEQ  = 5'b01010;
  localparam logic [4:0] c_OP_BNE  = 5'b01011;
  localparam logic [4:0] c_OP_BLT  = 5'b01100;
  localparam logic [4:0] c_OP_BGE  = 5'b01101;
  localparam logic [4:0] c_OP_BLTU = 5'b01110;
  localparam logic [4:0] c_OP_BGEU = 5'b01111;

  // Kind of multi-cycle operation latched at accept.
  localparam logic [1:0] c_K_SLL = 2'd0;
  localparam logic [1:0] c_K_SRL = 2'd1;
  localparam logic [1:0] c_K_SRA = 2'd2;
`ifdef ALU_PIPE_HS_MUL_EN
  localparam logic [4:0] c_OP_MUL = 5'b10000;
  localparam logic [1:0] c_K_MUL  = 2'd3;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid;
  logic            r_zero;
  logic            r_pcsrc;
  logic [XLEN-1:0] r_acc;     // shift operand in flight / product accumulator
  logic [CW-1:0]   r_rem;     // remaining shift positions / multiplier bits
  logic [1:0]      r_kind;
`ifdef ALU_PIPE_HS_MUL_EN
  logic [XLEN-1:0] r_mcand;   // multiplicand, moves left one bit per cycle
  logic [XLEN-1:0] r_mplier;  // multiplier, consumed LSB first
`endif

  // --------------------------------------------------------------------------
  // Operand selection and accept-time decode
  // --------------------------------------------------------------------------
  logic            w_accept;
  logic            w_is_branch_op;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_b;
  logic [LOG-1:0]  w_shamt;
  logic [XLEN-1:0] w_diff;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_eq;
  logic [XLEN-1:0] w_alu_res;
  logic            w_cond;
  logic            w_is_shift;
  logic            w_is_mul;
  logic [1:0]      w_kind;
  logic            w_pcsrc;
  logic            w_start_busy;

  // A new op can enter from IDLE, or from DONE in the cycle the result leaves.
  assign in_ready = rst_n & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
  assign w_accept = in_valid & in_ready;

  assign w_is_branch_op = (op >= c_OP_BEQ) && (op <= c_OP_BGEU);
  // Size cast of a signed value sign-extends (or truncates for XLEN < 12).
  assign w_imm_sext     = XLEN'($signed(imm));
  // Branches always compare rs1 against rs2, whatever alusrc says.
  assign w_b            = (alusrc && !w_is_branch_op) ? w_imm_sext : rs2;
  assign w_shamt        = w_b[LOG-1:0];
  assign w_diff         = rs1 - w_b;
  assign w_lt_s         = $signed(rs1) < $signed(w_b);
  assign w_lt_u         = rs1 < w_b;
  assign w_eq           = rs1 == w_b;

  always_comb begin
    w_alu_res  = '0;
    w_cond     = 1'b0;
    w_is_shift = 1'b0;
    w_is_mul   = 1'b0;
    w_kind     = c_K_SLL;
    case (op)
      c_OP_ADD:  w_alu_res = rs1 + w_b;
      c_OP_SUB:  w_alu_res = w_diff;
      c_OP_XOR:  w_alu_res = rs1 ^ w_b;
      c_OP_OR:   w_alu_res = rs1 | w_b;
      c_OP_AND:  w_alu_res = rs1 & w_b;
      // A zero-distance shift completes immediately with A as its result.
      c_OP_SLL:  begin w_alu_res = rs1; w_is_shift = 1'b1; w_kind = c_K_SLL; end
      c_OP_SRL:  begin w_alu_res = rs1; w_is_shift = 1'b1; w_kind = c_K_SRL; end
      c_OP_SRA:  begin w_alu_res = rs1; w_is_shift = 1'b1; w_kind = c_K_SRA; end
      c_OP_SLT:  w_alu_res = XLEN'(w_lt_s);
      c_OP_SLTU: w_alu_res = XLEN'(w_lt_u);
      c_OP_BEQ:  begin w_alu_res = w_diff; w_cond = w_eq;    end
      c_OP_BNE:  begin w_alu_res = w_diff; w_cond = !w_eq;   end
      c_OP_BLT:  begin w_alu_res = w_diff; w_cond = w_lt_s;  end
      c_OP_BGE:  begin w_alu_res = w_diff; w_cond = !w_lt_s; end
      c_OP_BLTU: begin w_alu_res = w_diff; w_cond = w_lt_u;  end
      c_OP_BGEU: begin w_alu_res = w_diff; w_cond = !w_lt_u; end
`ifdef ALU_PIPE_HS_MUL_EN
      c_OP_MUL:  begin w_is_mul = 1'b1; w_kind = c_K_MUL; end
`else
      // Undefined code when the multiplier is not built: result 0, one cycle.
`endif
      default:   w_alu_res = '0;
    endcase
  end

  // w_cond is only ever set for branch ops, so non-branch ops never redirect.
  assign w_pcsrc      = branch & w_cond;
  assign w_start_busy = (w_is_shift && (w_shamt != '0)) || w_is_mul;

  // --------------------------------------------------------------------------
  // Iterative datapath, one step per BUSY cycle
  // --------------------------------------------------------------------------
  logic [CW-1:0]   w_step;
  logic [CW-1:0]   w_busy_rem;
  logic [XLEN-1:0] w_busy_acc;
  logic            w_busy_last;

  // Last shift step may be shorter than SHIFT_STEP.
  assign w_step = (r_rem < c_STEP) ? r_rem : c_STEP;

  always_comb begin
    w_busy_rem = r_rem - w_step;
    case (r_kind)
      c_K_SLL: w_busy_acc = r_acc << w_step;
      c_K_SRL: w_busy_acc = r_acc >> w_step;
      // The accumulator's MSB stays equal to the original A[XLEN-1] across
      // every arithmetic step, so a signed shift fills with the right bit.
      c_K_SRA: w_busy_acc = $signed(r_acc) >>> w_step;
      default: w_busy_acc = r_acc;
    endcase
`ifdef ALU_PIPE_HS_MUL_EN
    if (r_kind == c_K_MUL) begin
      w_busy_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_busy_rem = r_rem - CW'(1);
    end
`endif
  end

  assign w_busy_last = (w_busy_rem == '0);

  // --------------------------------------------------------------------------
  // Control FSM and output hold register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_pcsrc     <= 1'b0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_kind      <= c_K_SLL;
`ifdef ALU_PIPE_HS_MUL_EN
      r_mcand     <= '0;
      r_mplier    <= '0;
`endif
    end else if (r_state == S_BUSY) begin
      r_acc <= w_busy_acc;
      r_rem <= w_busy_rem;
`ifdef ALU_PIPE_HS_MUL_EN
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
`endif
      if (w_busy_last) begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_busy_acc;
        r_zero      <= (w_busy_acc == '0);
        r_pcsrc     <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_start_busy) begin
        r_state     <= S_BUSY;
        r_out_valid <= 1'b0;
        r_acc       <= rs1;
        r_rem       <= CW'(w_shamt);
        r_kind      <= w_kind;
`ifdef ALU_PIPE_HS_MUL_EN
        if (w_is_mul) begin
          r_acc    <= '0;
          r_rem    <= CW'(XLEN);
          r_mcand  <= rs1;
          r_mplier <= w_b;
        end
`endif
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_alu_res;
        r_zero      <= (w_alu_res == '0);
        r_pcsrc     <= w_pcsrc;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign pcsrc     = r_pcsrc;
  assign busy      = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe_hs
// Purpose  : Self-checking bench for alu_pipe_hs (XLEN=32, SHIFT_STEP=1).
//            Directed scenarios are followed by randomized ops. All ops are
//            checked against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_hs;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      op = '0;
  logic            alusrc = 1'b0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [11:0]     imm = '0;
  logic            branch = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            pcsrc;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_pipe_hs #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .alusrc(alusrc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .branch(branch), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .pcsrc(pcsrc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        pc;
    int          lat;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: RV32I semantics written directly from the op table.
  function automatic exp_t model(input logic [4:0] o, input logic as,
                                 input logic [31:0] a, input logic [31:0] r2,
                                 input logic [11:0] im, input logic br);
    exp_t        e;
    logic [31:0] b;
    int          sh;
    logic        cond;
    logic [63:0] prod;
    e.res = 32'h0; e.pc = 1'b0; e.lat = 1; cond = 1'b0;
    b  = (as && !(o >= 5'd10 && o <= 5'd15)) ? {{20{im[11]}}, im} : r2;
    sh = int'(b[4:0]);
    prod = {32'h0, a} * {32'h0, b};
    case (o)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a ^ b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = a & b;
      5'd5:  begin e.res = a << sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
      5'd6:  begin e.res = a >> sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
      5'd7:  begin e.res = 32'($signed(a) >>> sh); e.lat = 1 + (sh + STEP - 1) / STEP; end
      5'd8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
        e.res = a - r2;
        case (o)
          5'd10:   cond = (a == r2);
          5'd11:   cond = (a != r2);
          5'd12:   cond = ($signed(a) <  $signed(r2));
          5'd13:   cond = ($signed(a) >= $signed(r2));
          5'd14:   cond = (a <  r2);
          default: cond = (a >= r2);
        endcase
        e.pc = br & cond;
      end
`ifdef ALU_PIPE_HS_MUL_EN
      5'd16: begin e.res = prod[31:0]; e.lat = XLEN + 1; end
`endif
      default: e.res = 32'h0;
    endcase
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // Issue one op from IDLE, wait for its result (bounded), hold it for `hold`
  // stalled cycles, then take it. Called at posedge+1.
  task automatic run_op(input logic [4:0] o, input logic as, input logic [31:0] a,
                        input logic [31:0] r2, input logic [11:0] im, input logic br,
                        input int hold, output logic [31:0] got_res,
                        output logic got_z, output logic got_pc);
    exp_t e;
    int   cyc;
    e = model(o, as, a, r2, im, br);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; alusrc = as; rs1 = a; rs2 = r2; imm = im; branch = br; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: only the accept-edge values may matter.
    in_valid = 1'b0;
    op = 5'($urandom); rs1 = $urandom; rs2 = $urandom; imm = 12'($urandom);
    alusrc = 1'($urandom); branch = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      chk("busy_wait", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(e.lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", result, e.res);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    chk("result", result, e.res);
    chk("zero", 32'(zero), 32'(e.z));
    chk("pcsrc", 32'(pcsrc), 32'(e.pc));
    chk("busy_done", 32'(busy), 32'd0);
    got_res = result; got_z = zero; got_pc = pcsrc;
    out_ready = 1'b1;
    #1;
    chk("in_ready_done", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        z;
    logic        pc;
    logic [4:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    // ---- Reset state ----
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_pcsrc", 32'(pcsrc), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ---- ADD with sign-extended immediate ----
    run_op(5'd0, 1'b1, 32'h0000_0010, 32'h0, 12'hFFF, 1'b0, 0, r, z, pc);
    chk("add_imm_result", r, 32'h0000_000F);
    chk("add_imm_zero", 32'(z), 32'd0);

    // ---- SRA of a negative value ----
    run_op(5'd7, 1'b0, 32'h8000_0000, 32'd4, 12'h0, 1'b0, 0, r, z, pc);
    chk("sra_result", r, 32'hF800_0000);

    // ---- Branch compares ----
    run_op(5'd12, 1'b0, 32'hFFFF_FFFF, 32'd1, 12'h0, 1'b1, 0, r, z, pc);
    chk("blt_pcsrc", 32'(pc), 32'd1);
    run_op(5'd14, 1'b0, 32'hFFFF_FFFF, 32'd1, 12'h0, 1'b1, 0, r, z, pc);
    chk("bltu_pcsrc", 32'(pc), 32'd0);
    run_op(5'd10, 1'b1, 32'd7, 32'd7, 12'h123, 1'b0, 0, r, z, pc);
    chk("beq_zero", 32'(z), 32'd1);
    chk("beq_pcsrc", 32'(pc), 32'd0);

    // ---- Shift by zero completes in one cycle ----
    run_op(5'd5, 1'b1, 32'h1234_5678, 32'h0, 12'h020, 1'b0, 0, r, z, pc);
    chk("sll0_result", r, 32'h1234_5678);

    // ---- Backpressure then back-to-back accept ----
    op = 5'd1; alusrc = 1'b0; rs1 = 32'd9; rs2 = 32'd9; branch = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'h0);
      chk("bp_zero", 32'(zero), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    op = 5'd2; rs1 = 32'hA5; rs2 = 32'h0F; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_result", result, 32'hAA);
    chk("b2b_zero", 32'(zero), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // ---- MUL (or undefined code when the multiplier is not built) ----
    run_op(5'd16, 1'b0, 32'h0001_0000, 32'h0001_0001, 12'h0, 1'b0, 0, r, z, pc);
`ifdef ALU_PIPE_HS_MUL_EN
    chk("mul_result", r, 32'h0001_0000);
`else
    chk("mul_undef_result", r, 32'h0);
`endif

    // ---- Reset in the middle of a shift ----
    op = 5'd6; alusrc = 1'b0; rs1 = 32'hFFFF_0000; rs2 = 32'd16; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midbusy_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midbusy_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("midbusy_out_valid", 32'(out_valid), 32'd0);
    chk("midbusy_busy_clr", 32'(busy), 32'd0);
    chk("midbusy_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midbusy_idle_ready", 32'(in_ready), 32'd1);
    chk("midbusy_idle_valid", 32'(out_valid), 32'd0);

    // ---- Randomized ops against the model ----
    for (int k = 0; k < 60; k++) begin
      ro = 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(ro, 1'($urandom), ra, rb, 12'($urandom), 1'($urandom),
             $urandom_range(0, 2), r, z, pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe_hs.md
Name: alu_pipe_hs

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU in the RISC-V datapath, sitting between register read and memory/writeback.
- Adds:
  - XLEN-wide operands and a sign-extended 12-bit immediate.
  - Full RV32I ALU op set and all six branch compares.
  - A multi-cycle iterative shifter.
  - A valid/ready interface with a one-entry output hold register, so downstream stalls are absorbed.

Parameters:
- XLEN, 32, operand/result width (≥8, power of 2).
- SHIFT_STEP, 1, bit positions shifted per BUSY cycle (1..XLEN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts request this cycle.
- op  in  5  operation code (see Behaviour).
- alusrc  in  1  1: operand B = sext(imm); 0: operand B = rs2. Ignored for branch ops.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  register operand B.
- imm  in  12  immediate, two's complement.
- branch  in  1  instruction is a conditional branch.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  ALU result.
- zero  out  1  result == 0.
- pcsrc  out  1  branch & condition true.
- busy  out  1  state == BUSY.

Behaviour:
- Op codes:
  - 00000 ADD, 00001 SUB, 00010 XOR, 00011 OR, 00100 AND.
  - 00101 SLL, 00110 SRL, 00111 SRA.
  - 01000 SLT, 01001 SLTU.
  - 01010 BEQ, 01011 BNE, 01100 BLT, 01101 BGE, 01110 BLTU, 01111 BGEU.
  - 10000 MUL (only when the macro is defined).
  - Any other code: result 0, pcsrc 0, treated as single-cycle.
- Immediate: sign-extended from bit 11 to XLEN.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN.
- Shift amount: B[log2(XLEN)-1:0] only.
- Compares: SLT/SLTU write 1 or 0 to result.
- Branch ops: result = rs1 - rs2; condition evaluated on rs1 vs rs2; pcsrc = branch & cond; with branch=0, pcsrc=0.
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On accept (in_valid & in_ready), single-cycle ops register result and go to DONE.
  - Shifts with shamt≠0 latch operand/remaining count and go to BUSY.
  - Shifts with shamt=0 go to DONE with result=A.
- BUSY:
  - Each cycle shifts by min(SHIFT_STEP, remaining) and decrements remaining.
  - SRA fills with the original A[XLEN-1].
  - When remaining reaches 0, go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; result/zero/pcsrc held stable until out_ready.
  - in_ready = out_ready, so a new op is accepted in the same cycle the result is taken (back-to-back).
  - If out_ready & in_valid, process the new op as from IDLE.
  - If out_ready & !in_valid, go to IDLE.
  - If !out_ready, remain in DONE.
- Latency, accept edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - Shift: 1 + ceil(shamt/SHIFT_STEP) cycles.
- Reset (rst_n=0 at rising edge, any state, including mid-BUSY):
  - state=IDLE, out_valid=0, result=0, zero=0, pcsrc=0, busy=0, remaining count=0.
  - Any in-flight op is discarded.
  - in_ready=0 while rst_n=0.
- out_valid never drops without out_ready, except on reset.
- Inputs are sampled only at accept; later changes on rs1/rs2/op have no effect.

Optional Feature:
- Macro: ALU_PIPE_HS_MUL_EN.
- With the macro defined:
  - Op 10000 = MUL, low XLEN bits of A*B.
  - Iterative shift-add, one bit per BUSY cycle.
  - Latency XLEN+1 cycles; zero/pcsrc rules as for other ops.
- Without the macro: 10000 is an undefined code (result 0, 1 cycle). No multiplier logic is synthesised.

Test Plan:
- Reset mid-BUSY: accept SRL rs1=0xFFFF0000, rs2=16, assert rst_n=0 on cycle 3 → next cycle out_valid=0, busy=0, result=0, state IDLE.
- ADD with alusrc=1, rs1=0x00000010, imm=0xFFF → 1 cycle later out_valid=1, result=0x0000000F, zero=0.
- SRA rs1=0x80000000, rs2=4, SHIFT_STEP=1 → busy for 4 cycles, out_valid on cycle 5, result=0xF8000000.
- Branch ops:
  - BLT branch=1, rs1=0xFFFFFFFF, rs2=1 → pcsrc=1.
  - Same operands with BLTU → pcsrc=0.
  - BEQ rs1=rs2=7, branch=0 → zero=1, pcsrc=0.
- Backpressure: hold out_ready=0 for 5 cycles after SUB 9-9 → result=0, zero=1 stable, in_ready=0. Raise out_ready with in_valid=1 (XOR 0xA5^0x0F) → SUB taken and XOR accepted same edge; next cycle result=0xAA.
- With ALU_PIPE_HS_MUL_EN: MUL 0x00010000*0x00010001 → after 33 cycles result=0x00010000. Without the macro: same op → 1 cycle, result=0.
